// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types for the two-master memory/IO arbiter.
//   state_e  - arbiter FSM encoding (Idle -> Access -> Resp).
//   target_e - address decode result (data memory, IO block, unmapped).
//   Len*     - mem_len encodings forwarded unchanged from the requester.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TgtMem  = 2'd0,
    TgtIo   = 2'd1,
    TgtNone = 2'd2
  } target_e;

  localparam logic [2:0] LenByte  = 3'd0;
  localparam logic [2:0] LenHalf  = 3'd1;
  localparam logic [2:0] LenWord  = 3'd2;
  localparam logic [2:0] LenDword = 3'd3;

endpackage

// File: rtl/mem_arb_decode.sv
// mem_arb_decode: combinational address decoder for mem_arbiter.
//   i_addr   - registered transaction address
//   o_target - TgtMem for 0..DATA_SIZE-1, TgtIo for exactly IO_ADDR, otherwise TgtNone.
// The data-memory range is checked first, so it wins if IO_ADDR falls inside it.
module mem_arb_decode
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DATA_SIZE = 256,
  parameter int unsigned IO_ADDR   = 256
) (
  input  logic [WIDTH-1:0] i_addr,
  output target_e          o_target
);

  localparam logic [WIDTH-1:0] DataLimit = WIDTH'(DATA_SIZE);
  localparam logic [WIDTH-1:0] IoAddr    = WIDTH'(IO_ADDR);

  always_comb begin
    if (i_addr < DataLimit) begin
      o_target = TgtMem;
    end else if (i_addr == IoAddr) begin
      o_target = TgtIo;
    end else begin
      o_target = TgtNone;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two masters onto a data memory and a single-address IO block.
// Each transaction takes three cycles: Idle (capture) -> Access (grant) -> Resp (ack).
//   CLK, RST                 - clock; asynchronous active-high reset
//   mX_req/we/addr/wdata/len - request from master X (held until mX_ack)
//   mX_gnt, mX_ack, mX_rdata - grant during Access, one-cycle ack plus read data in Resp
//   mem_addr/wdata/len       - driven from the captured request during Access
//   mem_re/we/ce, io_we      - decoded enables during Access
//   mem_rdata, io_rdata      - read data returned in the Resp cycle
//   err                      - one-cycle pulse with ack for an unmapped address
// Build option: define MEM_ARB_RR_EN for round-robin arbitration; otherwise master 0 has
// fixed priority and no pointer state exists.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DATA_SIZE = 256,
  parameter int unsigned IO_ADDR   = 256
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_addr,
  input  logic [WIDTH-1:0] m0_wdata,
  input  logic [2:0]       m0_len,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_addr,
  input  logic [WIDTH-1:0] m1_wdata,
  input  logic [2:0]       m1_len,
  output logic             m0_gnt,
  output logic             m0_ack,
  output logic [WIDTH-1:0] m0_rdata,
  output logic             m1_gnt,
  output logic             m1_ack,
  output logic [WIDTH-1:0] m1_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [2:0]       mem_len,
  output logic             mem_re,
  output logic             mem_we,
  output logic             mem_ce,
  output logic             io_we,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [WIDTH-1:0] io_rdata,
  output logic             err
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_owner;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [2:0]       r_len;

  logic             w_capture;
  logic             w_winner;
  logic [WIDTH-1:0] w_rdata;
  target_e          w_target;

  assign w_capture = (r_state == StIdle) && (m0_req || m1_req);

`ifdef MEM_ARB_RR_EN
  // r_rr_ptr names the master that wins a tie; it points away from the last winner.
  logic r_rr_ptr;

  always_comb begin
    w_winner = (m0_req && m1_req) ? r_rr_ptr : m1_req;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rr_ptr <= 1'b0;
    end else if (w_capture) begin
      r_rr_ptr <= ~w_winner;
    end
  end
`else
  assign w_winner = ~m0_req;
`endif

  mem_arb_decode #(
    .WIDTH    (WIDTH),
    .DATA_SIZE(DATA_SIZE),
    .IO_ADDR  (IO_ADDR)
  ) u_decode (
    .i_addr  (r_addr),
    .o_target(w_target)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= StIdle;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_owner <= w_winner;
        r_we    <= w_winner ? m1_we    : m0_we;
        r_addr  <= w_winner ? m1_addr  : m0_addr;
        r_wdata <= w_winner ? m1_wdata : m0_wdata;
        r_len   <= w_winner ? m1_len   : m0_len;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rdata      = '0;
    m0_gnt       = 1'b0;
    m1_gnt       = 1'b0;
    m0_ack       = 1'b0;
    m1_ack       = 1'b0;
    m0_rdata     = '0;
    m1_rdata     = '0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_len      = '0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    mem_ce       = 1'b0;
    io_we        = 1'b0;
    err          = 1'b0;

    case (r_state)
      StIdle: begin
        if (m0_req || m1_req) begin
          w_state_next = StAccess;
        end
      end

      StAccess: begin
        w_state_next = StResp;
        m0_gnt       = ~r_owner;
        m1_gnt       = r_owner;
        mem_addr     = r_addr;
        mem_wdata    = r_wdata;
        mem_len      = r_len;
        case (w_target)
          TgtMem: begin
            mem_ce = 1'b1;
            mem_re = ~r_we;
            mem_we = r_we;
          end
          TgtIo:   io_we = r_we;
          default: ;
        endcase
      end

      StResp: begin
        w_state_next = StIdle;
        m0_ack       = ~r_owner;
        m1_ack       = r_owner;
        err          = (w_target == TgtNone);
        // Writes and unmapped accesses return zero.
        if (!r_we) begin
          case (w_target)
            TgtMem:  w_rdata = mem_rdata;
            TgtIo:   w_rdata = io_rdata;
            default: w_rdata = '0;
          endcase
        end
        m0_rdata = r_owner ? '0 : w_rdata;
        m1_rdata = r_owner ? w_rdata : '0;
      end

      default: w_state_next = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter.
// Expected completions are pushed to a scoreboard queue when a request is driven and
// popped when the matching ack appears. Define MEM_ARB_RR_EN to check the round-robin build.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned W = 32;

  logic         CLK = 1'b0;
  logic         RST;
  logic         m0_req, m0_we, m1_req, m1_we;
  logic [W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]   m0_len, m1_len;
  logic         m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [W-1:0] m0_rdata, m1_rdata;
  logic [W-1:0] mem_addr, mem_wdata;
  logic [2:0]   mem_len;
  logic         mem_re, mem_we, mem_ce, io_we, err;
  logic [W-1:0] mem_rdata, io_rdata;

  typedef struct {
    bit           owner;
    logic [W-1:0] rdata;
    bit           err;
  } exp_t;

  typedef struct packed {
    logic         who;
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    logic [3:0]   en;     // {mem_re, mem_we, mem_ce, io_we} during Access
    logic [W-1:0] rdata;
    logic         err;
  } vec_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter #(
    .WIDTH    (W),
    .DATA_SIZE(256),
    .IO_ADDR  (256)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_len   (m0_len),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_len   (m1_len),
    .m0_gnt   (m0_gnt),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_gnt   (m1_gnt),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_len  (mem_len),
    .mem_re   (mem_re),
    .mem_we   (mem_we),
    .mem_ce   (mem_ce),
    .io_we    (io_we),
    .mem_rdata(mem_rdata),
    .io_rdata (io_rdata),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [8:0] ctrl_vec();
    return {m0_gnt, m1_gnt, m0_ack, m1_ack, mem_re, mem_we, mem_ce, io_we, err};
  endfunction

  function automatic logic [5*W+2:0] data_vec();
    return {mem_addr, mem_wdata, mem_len, m0_rdata, m1_rdata};
  endfunction

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_len = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_len = '0;
  endtask

  // Requests from one master; the other master sees junk with req low.
  task automatic drive(input bit who, input bit we, input logic [W-1:0] addr,
                       input logic [W-1:0] wdata, input logic [2:0] len);
    m0_req = ~who;
    m1_req = who;
    if (!who) begin
      m0_we = we;  m0_addr = addr;  m0_wdata = wdata;  m0_len = len;
      m1_we = ~we; m1_addr = ~addr; m1_wdata = ~wdata; m1_len = ~len;
    end else begin
      m1_we = we;  m1_addr = addr;  m1_wdata = wdata;  m1_len = len;
      m0_we = ~we; m0_addr = ~addr; m0_wdata = ~wdata; m0_len = ~len;
    end
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!(m0_ack || m1_ack) && n < 6);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b0, 1'b0, 32'h33, 32'h44, LenWord);
    mem_rdata = 32'h1111_2222;
    io_rdata  = 32'h3333_4444;
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (ctrl_vec() !== 9'd0 || data_vec() !== '0) begin
        failures++;
        $display("FAIL reset_outputs ctrl=%b data=%h want all zero", ctrl_vec(), data_vec());
      end
    end
    idle_inputs();
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (ctrl_vec() !== 9'd0) begin
      failures++;
      $display("FAIL reset_release_idle ctrl=%b want 0", ctrl_vec());
    end
  endtask

  task automatic test_decode();
    vec_t         v[8];
    exp_t         e;
    int           n;
    logic [W-1:0] got;
    v[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        4'b1010, 32'hDEADBEEF, 1'b0};
    v[1] = '{1'b1, 1'b1, 32'h20,  32'hCAFE0001, 4'b0110, 32'h0,        1'b0};
    v[2] = '{1'b0, 1'b0, 32'hFF,  32'h0,        4'b1010, 32'hDEADBEEF, 1'b0};
    v[3] = '{1'b1, 1'b1, 32'h100, 32'h55,       4'b0001, 32'h0,        1'b0};
    v[4] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'b0000, 32'h12345678, 1'b0};
    v[5] = '{1'b0, 1'b0, 32'h400, 32'h0,        4'b0000, 32'h0,        1'b1};
    v[6] = '{1'b1, 1'b0, 32'h101, 32'h0,        4'b0000, 32'h0,        1'b1};
    v[7] = '{1'b1, 1'b1, 32'h400, 32'h77,       4'b0000, 32'h0,        1'b1};
    mem_rdata = 32'hDEADBEEF;
    io_rdata  = 32'h12345678;
    for (int i = 0; i < 8; i++) begin
      drive(v[i].who, v[i].we, v[i].addr, v[i].wdata, 3'(i));
      sb_q.push_back('{owner: v[i].who, rdata: v[i].rdata, err: v[i].err});
      @(negedge CLK);
      checks++;
      if ({m1_gnt, m0_gnt} !== (v[i].who ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL decode_gnt row=%0d got=%b want=%b", i, {m1_gnt, m0_gnt},
                 v[i].who ? 2'b10 : 2'b01);
      end
      checks++;
      if ({mem_re, mem_we, mem_ce, io_we} !== v[i].en) begin
        failures++;
        $display("FAIL decode_enables row=%0d got=%b want=%b", i,
                 {mem_re, mem_we, mem_ce, io_we}, v[i].en);
      end
      checks++;
      if (mem_addr !== v[i].addr || mem_wdata !== v[i].wdata || mem_len !== 3'(i)) begin
        failures++;
        $display("FAIL decode_bus row=%0d got=%h/%h/%0d want=%h/%h/%0d", i, mem_addr,
                 mem_wdata, mem_len, v[i].addr, v[i].wdata, i);
      end
      checks++;
      if ({m1_ack, m0_ack, err} !== 3'b000) begin
        failures++;
        $display("FAIL decode_early_ack row=%0d got=%b want=000", i, {m1_ack, m0_ack, err});
      end
      // Dropping req after capture must not cancel the transaction.
      m0_req = 1'b0;
      m1_req = 1'b0;
      wait_ack(n);
      checks++;
      if (n != 1) begin
        failures++;
        $display("FAIL decode_latency row=%0d got=%0d want=1 cycle after grant", i, n);
      end
      e   = sb_q.pop_front();
      got = e.owner ? m1_rdata : m0_rdata;
      checks++;
      if ({m1_ack, m0_ack} !== (e.owner ? 2'b10 : 2'b01) || got !== e.rdata || err !== e.err)
      begin
        failures++;
        $display("FAIL decode_resp row=%0d got ack=%b rdata=%h err=%b want owner=%0d rdata=%h err=%b",
                 i, {m1_ack, m0_ack}, got, err, e.owner, e.rdata, e.err);
      end
      checks++;
      if ((e.owner ? m0_rdata : m1_rdata) !== '0 ||
          {m1_gnt, m0_gnt, mem_re, mem_we, mem_ce, io_we} !== 6'd0) begin
        failures++;
        $display("FAIL decode_resp_quiet row=%0d other_rdata=%h ctl=%b want 0", i,
                 e.owner ? m0_rdata : m1_rdata, {m1_gnt, m0_gnt, mem_re, mem_we, mem_ce, io_we});
      end
      @(negedge CLK);
      checks++;
      if ({m1_ack, m0_ack, err} !== 3'b000) begin
        failures++;
        $display("FAIL decode_ack_pulse row=%0d got=%b want=000", i, {m1_ack, m0_ack, err});
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    bit exp_q[$];
    int last;
    int grants;
    @(negedge CLK);
    RST = 1'b1;
    idle_inputs();
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      exp_q.push_back(bit'(i % 2));
`else
      exp_q.push_back(1'b0);
`endif
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4; m0_len = LenWord;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h8; m1_len = LenByte;
    grants = 0;
    last   = 0;
    for (int c = 1; c <= 20 && grants < 4; c++) begin
      @(negedge CLK);
      checks++;
      if ((m0_gnt && m1_gnt) || (m0_ack && m1_ack)) begin
        failures++;
        $display("FAIL b2b_exclusive cycle=%0d gnt=%b ack=%b want at most one each", c,
                 {m1_gnt, m0_gnt}, {m1_ack, m0_ack});
      end
      if (m0_gnt || m1_gnt) begin
        checks++;
        if (m1_gnt !== exp_q[grants]) begin
          failures++;
          $display("FAIL b2b_order grant=%0d got=m%0d want=m%0d", grants, m1_gnt,
                   exp_q[grants]);
        end
        checks++;
        if (c - last != (grants == 0 ? 1 : 3)) begin
          failures++;
          $display("FAIL b2b_spacing grant=%0d got=%0d want=%0d cycles", grants, c - last,
                   grants == 0 ? 1 : 3);
        end
        last = c;
        grants++;
      end
    end
    checks++;
    if (grants != 4) begin
      failures++;
      $display("FAIL b2b_timeout got=%0d grants want=4", grants);
    end
    idle_inputs();
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_abort();
    exp_t e;
    int   n;
    mem_rdata = 32'hA5A55A5A;
    @(negedge CLK);
    drive(1'b0, 1'b0, 32'h10, 32'h0, LenWord);
    @(negedge CLK);
    checks++;
    if (m0_gnt !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_gnt got=%b want=1", m0_gnt);
    end
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h30; m1_wdata = '0; m1_len = LenHalf;
    #2 RST = 1'b1;
    #1;
    checks++;
    if (ctrl_vec() !== 9'd0 || data_vec() !== '0) begin
      failures++;
      $display("FAIL abort_async ctrl=%b data=%h want all zero", ctrl_vec(), data_vec());
    end
    @(negedge CLK);
    checks++;
    if (ctrl_vec() !== 9'd0) begin
      failures++;
      $display("FAIL abort_no_ack ctrl=%b want 0", ctrl_vec());
    end
    RST = 1'b0;
    sb_q.delete();
    sb_q.push_back('{owner: 1'b1, rdata: 32'hA5A55A5A, err: 1'b0});
    @(negedge CLK);
    checks++;
    if ({m1_gnt, m0_gnt} !== 2'b10 || m0_ack !== 1'b0) begin
      failures++;
      $display("FAIL abort_regrant got gnt=%b m0_ack=%b want gnt=10 m0_ack=0",
               {m1_gnt, m0_gnt}, m0_ack);
    end
    m1_req = 1'b0;
    wait_ack(n);
    checks++;
    if (n != 1) begin
      failures++;
      $display("FAIL abort_latency got=%0d want=1", n);
    end
    e = sb_q.pop_front();
    checks++;
    if ({m1_ack, m0_ack} !== 2'b10 || m1_rdata !== e.rdata || err !== e.err) begin
      failures++;
      $display("FAIL abort_resp got ack=%b rdata=%h err=%b want ack=10 rdata=%h err=%b",
               {m1_ack, m0_ack}, m1_rdata, err, e.rdata, e.err);
    end
    idle_inputs();
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_decode();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
